// File: rtl/bht_sat_table.sv
// Saturating-counter branch history table, swept to weakly-not-taken after reset/flush; lookup latency 1 cycle.
// Backpressure: ready is low for the DEPTH-cycle sweep and requests are dropped then; in RUN every cycle is accepted.
module bht_sat_table #(
  parameter int CNT_W = 2,
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  output logic             ready,
  input  logic             lookup_valid,
  input  logic [IDX_W-1:0] lookup_idx,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [CNT_W-1:0] pred_count,
  input  logic             update_valid,
  input  logic [IDX_W-1:0] update_idx,
  input  logic             update_taken
);

  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] WNT = MAX >> 1;

  typedef enum logic {INIT, RUN} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] mem [DEPTH];

  logic [CNT_W-1:0] upd_cur;
  logic [CNT_W-1:0] upd_nxt;
  logic             upd_en;
  logic [CNT_W-1:0] lk_val;
  logic             we;
  logic [IDX_W-1:0] waddr;
  logic [CNT_W-1:0] wdata;

  assign ready   = (state == RUN);
  assign upd_cur = mem[update_idx];
  // A flush in the same cycle discards the update.
  assign upd_en  = ready && update_valid && !flush;

  always_comb begin
    upd_nxt = upd_cur;
    if (update_taken) begin
      if (upd_cur != MAX) upd_nxt = upd_cur + CNT_W'(1);
    end else begin
      if (upd_cur != '0) upd_nxt = upd_cur - CNT_W'(1);
    end
  end

  // Same-index lookup sees the value being written this cycle.
  assign lk_val = (upd_en && (update_idx == lookup_idx)) ? upd_nxt : mem[lookup_idx];

  always_comb begin
    we    = 1'b0;
    waddr = ptr;
    wdata = WNT;
    if (state == INIT) begin
      we = 1'b1;
    end else if (upd_en) begin
      we    = 1'b1;
      waddr = update_idx;
      wdata = upd_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= INIT;
      ptr        <= '0;
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_count <= '0;
    end else if (state == INIT) begin
      pred_valid <= 1'b0;
      if (flush) begin
        ptr <= '0;
      end else if (ptr == IDX_W'(DEPTH - 1)) begin
        state <= RUN;
        ptr   <= '0;
      end else begin
        ptr <= ptr + IDX_W'(1);
      end
    end else begin
      pred_valid <= lookup_valid;
      if (lookup_valid) begin
        pred_count <= lk_val;
        pred_taken <= lk_val[CNT_W-1];
      end
      if (flush) begin
        state <= INIT;
        ptr   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bht_sat_table.sv
// Scoreboard bench: default table (2-bit x 64) and a 3-bit x 16 table driven in parallel.
module tb_bht_sat_table;

  logic       clk = 1'b0;
  logic       reset, flush, lookup_valid, update_valid, update_taken;
  logic [5:0] lookup_idx, update_idx;
  logic [3:0] lookup_idx3, update_idx3;
  logic       ready0, pv0, pt0;
  logic [1:0] pc0;
  logic       ready3, pv3, pt3;
  logic [2:0] pc3;

  int nchk = 0;
  int nfail = 0;
  int mdl [2][64];
  int left [2];
  int q0 [$];
  int q1 [$];
  int last0 = 0;
  int last3 = 0;
  int e0, e3;

  bht_sat_table dut (
    .clk(clk), .reset(reset), .flush(flush), .ready(ready0),
    .lookup_valid(lookup_valid), .lookup_idx(lookup_idx),
    .pred_valid(pv0), .pred_taken(pt0), .pred_count(pc0),
    .update_valid(update_valid), .update_idx(update_idx), .update_taken(update_taken)
  );

  bht_sat_table #(.CNT_W(3), .DEPTH(16)) dut3 (
    .clk(clk), .reset(reset), .flush(flush), .ready(ready3),
    .lookup_valid(lookup_valid), .lookup_idx(lookup_idx3),
    .pred_valid(pv3), .pred_taken(pt3), .pred_count(pc3),
    .update_valid(update_valid), .update_idx(update_idx3), .update_taken(update_taken)
  );

  always #5 clk = ~clk;

  function automatic int dep(int k);  return (k == 0) ? 64 : 16; endfunction
  function automatic int maxv(int k); return (k == 0) ? 3 : 7;   endfunction
  function automatic int wnt(int k);  return (k == 0) ? 1 : 3;   endfunction

  function automatic int satf(int v, int k, bit t);
    if (t) return (v < maxv(k)) ? v + 1 : v;
    return (v > 0) ? v - 1 : 0;
  endfunction

  task automatic chk(string name, int act, int exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Apply one cycle of inputs and advance the reference model for both tables.
  task automatic drive(bit lv, int li, bit uv, int ui, bit ut, bit fl);
    lookup_valid = lv;  lookup_idx = 6'(li); lookup_idx3 = 4'(li);
    update_valid = uv;  update_idx = 6'(ui); update_idx3 = 4'(ui);
    update_taken = ut;  flush = fl;
    for (int k = 0; k < 2; k++) begin
      int l, u, nv, e;
      l = li % dep(k);
      u = ui % dep(k);
      chk((k == 0) ? "ready" : "ready3", (k == 0) ? int'(ready0) : int'(ready3), int'(left[k] == 0));
      if (left[k] == 0) begin
        nv = satf(mdl[k][u], k, ut);
        if (lv) begin
          e = (uv && !fl && l == u) ? nv : mdl[k][l];
          if (k == 0) q0.push_back(e); else q1.push_back(e);
        end
        if (fl) begin
          left[k] = dep(k);
          for (int i = 0; i < 64; i++) mdl[k][i] = wnt(k);
        end else if (uv) begin
          mdl[k][u] = nv;
        end
      end else if (fl) begin
        left[k] = dep(k);
      end else begin
        left[k]--;
      end
    end
  endtask

  task automatic cyc(bit lv, int li, bit uv, int ui, bit ut, bit fl);
    @(posedge clk);
    #1;
    drive(lv, li, uv, ui, ut, fl);
  endtask

  task automatic idle(int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset mid-cycle; outputs must drop at once, then the release cycle starts the sweep.
  task automatic hit_reset();
    #2;
    reset = 1'b1;
    lookup_valid = 0; update_valid = 0; update_taken = 0; flush = 0;
    #1;
    chk("rst_pv", pv0, 0);    chk("rst_pc", pc0, 0);   chk("rst_pt", pt0, 0);
    chk("rst_ready", ready0, 0);
    chk("rst_pv3", pv3, 0);   chk("rst_pc3", pc3, 0);  chk("rst_ready3", ready3, 0);
    q0.delete();
    q1.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      left[k] = dep(k);
      for (int i = 0; i < 64; i++) mdl[k][i] = wnt(k);
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      chk("mon_rst_pv", pv0, 0);
      chk("mon_rst_pc", pc0, 0);
      last0 = 0;
    end else if (pv0) begin
      if (q0.size() == 0) begin
        chk("unexpected_pred_valid", 1, 0);
      end else begin
        e0 = q0.pop_front();
        chk("pred_count", pc0, e0);
        chk("pred_taken", pt0, (e0 >> 1) & 1);
        last0 = e0;
      end
    end else begin
      chk("hold_count", pc0, last0);
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("mon_rst_pv3", pv3, 0);
      chk("mon_rst_pc3", pc3, 0);
      last3 = 0;
    end else if (pv3) begin
      if (q1.size() == 0) begin
        chk("unexpected_pred_valid3", 1, 0);
      end else begin
        e3 = q1.pop_front();
        chk("pred_count3", pc3, e3);
        chk("pred_taken3", pt3, (e3 >> 2) & 1);
        last3 = e3;
      end
    end else begin
      chk("hold_count3", pc3, last3);
    end
  end

  initial begin
    reset = 1'b1;
    lookup_valid = 0; update_valid = 0; update_taken = 0; flush = 0;
    lookup_idx = '0; update_idx = '0; lookup_idx3 = '0; update_idx3 = '0;
    hit_reset();
    idle(63);
    cyc(1, 17, 0, 0, 0, 0);
    idle(1);
    chk("after_init_pc", pc0, 1);  chk("after_init_pt", pt0, 0);  chk("after_init_pc3", pc3, 3);

    // Saturation at both ends on idx 5.
    repeat (3) cyc(0, 0, 1, 5, 1, 0);
    cyc(1, 5, 0, 0, 0, 0);
    idle(1);
    chk("three_taken_pc3", pc3, 6);
    repeat (5) cyc(0, 0, 1, 5, 1, 0);
    cyc(1, 5, 0, 0, 0, 0);
    idle(1);
    chk("sat_hi_pc", pc0, 3);  chk("sat_hi_pt", pt0, 1);  chk("sat_hi_pc3", pc3, 7);
    repeat (4) cyc(0, 0, 1, 5, 0, 0);
    cyc(1, 5, 0, 0, 0, 0);
    idle(1);
    chk("sat_lo_pc", pc0, 0);
    cyc(0, 0, 1, 5, 0, 0);
    cyc(1, 5, 0, 0, 0, 0);
    idle(1);
    chk("no_wrap_pc", pc0, 0);  chk("no_wrap_pc3", pc3, 2);

    // Same-cycle lookup and update forward.
    cyc(1, 9, 1, 9, 1, 0);
    idle(1);
    chk("fwd_pc", pc0, 2);  chk("fwd_pt", pt0, 1);  chk("fwd_pc3", pc3, 4);

    // Flush with lookups attempted throughout the sweep.
    repeat (2) cyc(0, 0, 1, 3, 1, 0);
    cyc(1, 3, 0, 0, 0, 0);
    idle(1);
    chk("pre_flush_pc", pc0, 3);
    cyc(0, 0, 0, 0, 0, 1);
    repeat (64) cyc(1, 3, 0, 0, 0, 0);
    cyc(1, 3, 0, 0, 0, 0);
    idle(1);
    chk("post_flush_pc", pc0, 1);

    // Flush beats update; lookup in that cycle sees pre-flush value.
    cyc(0, 0, 1, 7, 1, 0);
    cyc(1, 7, 1, 7, 1, 1);
    idle(1);
    chk("flush_wins_pc", pc0, 2);  chk("flush_wins_pc3", pc3, 4);
    idle(70);

    for (int n = 0; n < 1500; n++) begin
      int li, ui;
      li = int'($urandom_range(0, 63));
      ui = ($urandom_range(0, 2) == 0) ? li : int'($urandom_range(0, 63));
      cyc(1'($urandom), li, 1'($urandom), ui, 1'($urandom), $urandom_range(0, 299) == 0);
    end
    idle(70);

    // Reset part-way through the sweep (pointer 30).
    hit_reset();
    idle(30);
    hit_reset();
    idle(70);
    cyc(1, 30, 0, 0, 0, 0);
    idle(1);
    chk("after_mid_reset_pc", pc0, 1);  chk("after_mid_reset_pc3", pc3, 3);

    idle(3);
    chk("queue_drained", q0.size(), 0);
    chk("queue_drained3", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/bht_sat_table.md
BHT_SAT_TABLE -- requirements
Module: bht_sat_table

Interface
REQ-001 Parameter CNT_W, default 2, width in bits of each saturating counter (legal 1..8).
REQ-002 Parameter DEPTH, default 64, number of counter entries (power of two, 2..1024).
REQ-003 Parameter IDX_W, default $clog2(DEPTH), width of entry index.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 flush  input  1  synchronous request to reinitialise whole table.
REQ-007 ready  output  1  high when table accepts lookups and updates.
REQ-008 lookup_valid  input  1  lookup request this cycle.
REQ-009 lookup_idx  input  IDX_W  entry to read.
REQ-010 pred_valid  output  1  registered response valid.
REQ-011 pred_taken  output  1  registered prediction, MSB of counter.
REQ-012 pred_count  output  CNT_W  registered full counter value.
REQ-013 update_valid  input  1  resolved-branch update this cycle.
REQ-014 update_idx  input  IDX_W  entry to update.
REQ-015 update_taken  input  1  1 = branch taken, 0 = not taken.

Function
REQ-016 Each entry SHALL be an unsigned CNT_W-bit saturating counter; MAX = 2^CNT_W-1, WNT = 2^(CNT_W-1)-1.
REQ-017 Update SHALL set entry to min(cnt+1, MAX) when update_taken=1, max(cnt-1, 0) when update_taken=0; no wrap-around at either end.
REQ-018 FSM SHALL have states INIT and RUN; ready = (state==RUN).
REQ-019 INIT SHALL write WNT into one entry per cycle, sweep pointer 0..DEPTH-1; after writing DEPTH-1 SHALL go to RUN next cycle (INIT lasts exactly DEPTH cycles).
REQ-020 In RUN, flush=1 SHALL reset sweep pointer to 0 and enter INIT next cycle; flush in INIT SHALL restart sweep at 0.
REQ-021 In INIT, lookup_valid and update_valid SHALL be ignored; pred_valid SHALL be 0.
REQ-022 In RUN, a lookup SHALL produce pred_valid=1 with pred_count/pred_taken of entry lookup_idx one cycle later (latency 1); pred_valid=0 cycles after no lookup.
REQ-023 pred_count/pred_taken SHALL hold last value when pred_valid=0.
REQ-024 Update SHALL commit at rising edge ending the update cycle; visible to lookups from next cycle.
REQ-025 Same-cycle lookup and update to same index SHALL forward: prediction reflects post-update value.
REQ-026 Same-cycle lookup and update to different indices SHALL both complete independently.
REQ-027 flush and update_valid in same RUN cycle: flush wins, update discarded; lookup in that cycle still answered with pre-flush value.
REQ-028 CNT_W=1 SHALL degenerate to a 1-bit last-outcome table (WNT=0).

Reset
REQ-029 reset=1 SHALL asynchronously force state=INIT, sweep pointer=0, ready=0, pred_valid=0, pred_taken=0, pred_count=0.
REQ-030 Counter array contents need not be reset; INIT sweep after reset deassertion SHALL establish WNT in all entries before ready rises.
REQ-031 reset asserted mid-INIT or mid-RUN SHALL abandon any operation; sweep restarts from 0 after deassertion.

Verification
REQ-032 Defaults; release reset, hold flush=0 -> ready=0 for exactly 64 cycles then 1; lookup any idx -> pred_count=2'b01, pred_taken=0.
REQ-033 Four taken updates to idx 5 then lookup 5 -> pred_count=2'b11 (saturated), pred_taken=1; four not-taken then lookup -> 2'b00, not wrapped to 2'b11.
REQ-034 Lookup and taken-update both idx 9 same cycle from 2'b01 -> next cycle pred_count=2'b10, pred_taken=1.
REQ-035 Entries idx 3=2'b11; assert flush one cycle -> ready low 64 cycles; lookups during sweep give pred_valid=0; afterwards idx 3 reads 2'b01.
REQ-036 CNT_W=3, DEPTH=16: reset -> 16 INIT cycles, entries 3'b011; three taken updates -> 3'b110; five more -> 3'b111.
REQ-037 Assert reset mid-sweep (pointer 30) -> outputs zero immediately; after release full 64-cycle sweep before ready.
